bus_arbiter: RTL and testbench

Single-outstanding arbiter that shares one memory bus port between the instruction-fetch (IF) and memory (MEM) pipeline stages. Each stage raises a level request with address, size and (MEM only) write data, then receives a one-cycle done pulse with read data. The block sequences one bus transaction at a time: command, accept, response, done. MEM has priority, and a streak limit guarantees IF forward progress.

---
 rtl/bus_arbiter_pkg.sv | 34 +++
 rtl/bus_arbiter_if.sv | 24 ++
 rtl/bus_arbiter_pick.sv | 36 +++
 rtl/bus_arbiter.sv | 117 +++++++++++
 tb/tb_bus_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory-bus arbiter.
package bus_arbiter_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned STREAK_W = 4;

   // Access size codes; code 3 is reserved and travels to the bus untouched.
   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   // Grant select encoding.
   localparam logic GNT_IF  = 1'b0;
   localparam logic GNT_MEM = 1'b1;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_CMD  = 2'd1,
      ARB_RESP = 2'd2,
      ARB_DONE = 2'd3
   } arb_state_t;

   // Four bytes, byte 0 at the lowest address.
   typedef logic [3:0][7:0] word_t;

   // Command fields latched at grant and held while the command is presented.
   typedef struct packed {
      logic            rw;
      logic [XLEN-1:0] address;
      logic [1:0]      data_size;
      word_t           write_data;
   } bus_cmd_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Memory bus port: command channel plus single-beat response.
interface bus_arbiter_if;
   import bus_arbiter_pkg::*;

   logic            bus_valid;
   logic            bus_rw;
   logic [XLEN-1:0] bus_address;
   logic [1:0]      bus_data_size;
   word_t           bus_write_data;
   logic            bus_ready;
   logic            bus_rvalid;
   word_t           bus_read_data;

   modport master (
      output bus_valid, bus_rw, bus_address, bus_data_size, bus_write_data,
      input  bus_ready, bus_rvalid, bus_read_data
   );

   modport slave (
      input  bus_valid, bus_rw, bus_address, bus_data_size, bus_write_data,
      output bus_ready, bus_rvalid, bus_read_data
   );

endinterface

// File: rtl/bus_arbiter_pick.sv
// Priority policy: MEM wins ties unless its streak has reached the limit.
module bus_arbiter_pick
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned MAX_MEM_STREAK = 4
)(
   input  logic                if_request,
   input  logic                mem_request,
   input  logic [STREAK_W-1:0] mem_streak,
   output logic                grant_valid_c,
   output logic                grant_sel_c,
   output logic [STREAK_W-1:0] mem_streak_next_c
);

   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_MEM_STREAK);

   // Choose a winner and the streak value that goes with that choice.
   always_comb begin
      grant_valid_c     = if_request | mem_request;
      grant_sel_c       = GNT_IF;
      mem_streak_next_c = mem_streak;
      if (mem_request && !(if_request && (mem_streak >= STREAK_MAX))) begin
         grant_sel_c = GNT_MEM;
         if (if_request) begin
            mem_streak_next_c = (mem_streak >= STREAK_MAX) ? STREAK_MAX
                                                           : mem_streak + STREAK_W'(1);
         end else begin
            mem_streak_next_c = '0;
         end
      end else if (if_request) begin
         grant_sel_c       = GNT_IF;
         mem_streak_next_c = '0;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Single-outstanding arbiter sharing one memory bus between IF and MEM stages.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned MAX_MEM_STREAK = 4
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             if_stage_request,
   input  logic [XLEN-1:0]  if_stage_address,
   input  logic [1:0]       if_stage_data_size,
   output word_t            if_stage_read_data,
   output logic             if_stage_done,
   input  logic             mem_stage_request,
   input  logic             mem_stage_rw,
   input  logic [XLEN-1:0]  mem_stage_address,
   input  logic [1:0]       mem_stage_data_size,
   input  word_t            mem_stage_write_data,
   output word_t            mem_stage_read_data,
   output logic             mem_stage_done,
   bus_arbiter_if.master    bus
);

   arb_state_t          state;
   logic [STREAK_W-1:0] mem_streak;
   logic                gnt_sel;
   logic                cmd_valid;
   bus_cmd_t            cmd;

   logic                grant_valid_c;
   logic                grant_sel_c;
   logic [STREAK_W-1:0] mem_streak_next_c;

   bus_arbiter_pick #(
      .MAX_MEM_STREAK (MAX_MEM_STREAK)
   ) u_pick (
      .if_request        (if_stage_request),
      .mem_request       (mem_stage_request),
      .mem_streak        (mem_streak),
      .grant_valid_c     (grant_valid_c),
      .grant_sel_c       (grant_sel_c),
      .mem_streak_next_c (mem_streak_next_c)
   );

   // Transaction sequencer: grant, present command, await response, pulse done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= ARB_IDLE;
         mem_streak          <= '0;
         gnt_sel             <= GNT_IF;
         cmd_valid           <= 1'b0;
         cmd                 <= '0;
         if_stage_done       <= 1'b0;
         mem_stage_done      <= 1'b0;
         if_stage_read_data  <= '0;
         mem_stage_read_data <= '0;
      end else begin
         if_stage_done  <= 1'b0;
         mem_stage_done <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (grant_valid_c) begin
                  gnt_sel    <= grant_sel_c;
                  mem_streak <= mem_streak_next_c;
                  cmd_valid  <= 1'b1;
                  state      <= ARB_CMD;
                  if (grant_sel_c == GNT_MEM) begin
                     cmd.rw         <= mem_stage_rw;
                     cmd.address    <= mem_stage_address;
                     cmd.data_size  <= mem_stage_data_size;
                     cmd.write_data <= mem_stage_write_data;
                  end else begin
                     cmd.rw         <= 1'b0;
                     cmd.address    <= if_stage_address;
                     cmd.data_size  <= if_stage_data_size;
                     cmd.write_data <= '0;
                  end
               end
            end
            ARB_CMD: begin
               if (bus.bus_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= ARB_RESP;
               end
            end
            ARB_RESP: begin
               if (bus.bus_rvalid) begin
                  state <= ARB_DONE;
                  if (gnt_sel == GNT_MEM) begin
                     mem_stage_done <= 1'b1;
                     if (!cmd.rw) begin
                        mem_stage_read_data <= bus.bus_read_data;
                     end
                  end else begin
                     if_stage_done      <= 1'b1;
                     if_stage_read_data <= bus.bus_read_data;
                  end
               end
            end
            ARB_DONE: begin
               state <= ARB_IDLE;
            end
            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

   // Bus command outputs come straight from the latched registers.
   assign bus.bus_valid      = cmd_valid;
   assign bus.bus_rw         = cmd.rw;
   assign bus.bus_address    = cmd.address;
   assign bus.bus_data_size  = cmd.data_size;
   assign bus.bus_write_data = cmd.write_data;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter with a transaction-timing reference model.
module tb_bus_arbiter;
   import bus_arbiter_pkg::*;

   localparam int MAX_STREAK = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            if_stage_request;
   logic [XLEN-1:0] if_stage_address;
   logic [1:0]      if_stage_data_size;
   word_t           if_stage_read_data;
   logic            if_stage_done;
   logic            mem_stage_request;
   logic            mem_stage_rw;
   logic [XLEN-1:0] mem_stage_address;
   logic [1:0]      mem_stage_data_size;
   word_t           mem_stage_write_data;
   word_t           mem_stage_read_data;
   logic            mem_stage_done;

   bus_arbiter_if bus ();

   bus_arbiter #(.MAX_MEM_STREAK(MAX_STREAK)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .if_stage_request     (if_stage_request),
      .if_stage_address     (if_stage_address),
      .if_stage_data_size   (if_stage_data_size),
      .if_stage_read_data   (if_stage_read_data),
      .if_stage_done        (if_stage_done),
      .mem_stage_request    (mem_stage_request),
      .mem_stage_rw         (mem_stage_rw),
      .mem_stage_address    (mem_stage_address),
      .mem_stage_data_size  (mem_stage_data_size),
      .mem_stage_write_data (mem_stage_write_data),
      .mem_stage_read_data  (mem_stage_read_data),
      .mem_stage_done       (mem_stage_done),
      .bus                  (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: one transaction in flight, described by its grant edge and waits.
   bit              act = 1'b0;
   bit              sel;
   int              g, rw, vw, d;
   int              free_edge = 0;
   int              streak = 0;
   logic            x_rw;
   logic [XLEN-1:0] x_addr;
   logic [1:0]      x_size;
   word_t           x_wdata;
   word_t           exp_if_rd, exp_mem_rd;
   bit              just_reset = 1'b0;

   // Stimulus controls.
   int    if_left = 0, mem_left = 0;
   int    force_rw = -1, force_vw = -1;
   bit    scramble = 1'b0, junk = 1'b0, auto_req = 1'b0, rand_rst = 1'b0;
   bit    rst_cmd = 1'b1, rst_in_resp = 1'b0;
   int    stale_cnt = 0;
   bit    use_fixed_rd = 1'b0;
   word_t fixed_rd = '0;

   // Observation logs.
   bit              gnt_log[$];
   int              gcyc_log[$];
   int              done_log[$];
   int              rise_log[$];
   logic [XLEN-1:0] addr_log[$];
   bit              prev_valid = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h required 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic clear_logs();
      gnt_log.delete(); gcyc_log.delete(); done_log.delete();
      rise_log.delete(); addr_log.delete();
   endtask

   // One clock: update model for the edge just taken, check outputs, drive next inputs.
   task automatic step();
      bit exp_valid;
      bit quiet;
      @(negedge clk);
      cyc++;
      if (rst) begin
         act = 1'b0; free_edge = cyc + 1; streak = 0;
         exp_if_rd = '0; exp_mem_rd = '0; just_reset = 1'b1;
      end else begin
         just_reset = 1'b0;
         if (act && cyc == d && !x_rw) begin
            if (sel) exp_mem_rd = bus.bus_read_data;
            else     exp_if_rd  = bus.bus_read_data;
         end
         if (act && cyc > d) act = 1'b0;
         if (!act && cyc >= free_edge && (if_stage_request || mem_stage_request)) begin
            if (if_stage_request && mem_stage_request) sel = (streak != MAX_STREAK);
            else                                       sel = mem_stage_request;
            if (!sel)                  streak = 0;
            else if (if_stage_request) streak = (streak + 1 > MAX_STREAK) ? MAX_STREAK : streak + 1;
            else                       streak = 0;
            x_rw    = sel ? mem_stage_rw : 1'b0;
            x_addr  = sel ? mem_stage_address : if_stage_address;
            x_size  = sel ? mem_stage_data_size : if_stage_data_size;
            x_wdata = sel ? mem_stage_write_data : '0;
            rw = (force_rw >= 0) ? force_rw : int'($urandom_range(0, 3));
            vw = (force_vw >= 0) ? force_vw : int'($urandom_range(0, 3));
            g = cyc; d = g + 2 + rw + vw; free_edge = d + 2; act = 1'b1;
            gnt_log.push_back(sel);
            gcyc_log.push_back(g - 1);
         end
      end

      exp_valid = act && cyc <= g + rw;
      check("bus_valid", 32'(bus.bus_valid), 32'(exp_valid));
      if (exp_valid) begin
         check("bus_rw", 32'(bus.bus_rw), 32'(x_rw));
         check("bus_address", bus.bus_address, x_addr);
         check("bus_data_size", 32'(bus.bus_data_size), 32'(x_size));
         check("bus_write_data", bus.bus_write_data, x_wdata);
      end
      if (just_reset) begin
         check("reset bus_rw", 32'(bus.bus_rw), 32'd0);
         check("reset bus_address", bus.bus_address, 32'd0);
         check("reset bus_data_size", 32'(bus.bus_data_size), 32'd0);
         check("reset bus_write_data", bus.bus_write_data, 32'd0);
      end
      check("if_done", 32'(if_stage_done), 32'(act && cyc == d && !sel));
      check("mem_done", 32'(mem_stage_done), 32'(act && cyc == d && sel));
      check("if_read_data", if_stage_read_data, exp_if_rd);
      check("mem_read_data", mem_stage_read_data, exp_mem_rd);
      if (if_stage_done || mem_stage_done) done_log.push_back(cyc);
      if (bus.bus_valid && !prev_valid) begin
         rise_log.push_back(cyc);
         addr_log.push_back(bus.bus_address);
      end
      prev_valid = bus.bus_valid;

      // Responder: rvalid is only junk where the arbiter must ignore it (IDLE, CMD).
      quiet = !act || cyc <= g + rw;
      if (stale_cnt > 0) stale_cnt--;
      bus.bus_ready  = act && cyc == g + rw;
      bus.bus_rvalid = (act && cyc == d - 1) || (junk && quiet && $urandom_range(0, 2) == 0)
                       || stale_cnt == 1;
      bus.bus_read_data = use_fixed_rd ? fixed_rd : word_t'($urandom);
      rst = rst_cmd || (rand_rst && $urandom_range(0, 399) == 0);
      if (rst_in_resp && act && cyc > g + rw && cyc < d) begin
         rst = 1'b1; rst_in_resp = 1'b0; stale_cnt = 2;
      end

      // Requesters retire on a seen done and may immediately present a new request.
      if (if_stage_done && if_left > 0) begin
         if_left--; if_stage_address = if_stage_address + 32'd4;
      end
      if (mem_stage_done && mem_left > 0) begin
         mem_left--; mem_stage_address = mem_stage_address + 32'd4;
      end
      if (auto_req) begin
         if (if_left == 0 && $urandom_range(0, 3) == 0)  if_left  = int'($urandom_range(1, 3));
         if (mem_left == 0 && $urandom_range(0, 3) == 0) mem_left = int'($urandom_range(1, 3));
      end
      if_stage_request  = if_left > 0;
      mem_stage_request = mem_left > 0;
      if (scramble) begin
         if_stage_address     = $urandom;
         if_stage_data_size   = 2'($urandom);
         mem_stage_rw         = 1'($urandom);
         mem_stage_address    = $urandom;
         mem_stage_data_size  = 2'($urandom);
         mem_stage_write_data = word_t'($urandom);
      end
   endtask

   task automatic run_until(input string tag, input int n_done, input int n_grant, input int budget);
      int k;
      bit met;
      k = 0; met = 1'b0;
      while (!met && k < budget) begin
         step(); k++;
         met = done_log.size() >= n_done && gnt_log.size() >= n_grant;
      end
      check({tag, " completes in time"}, 32'(met), 32'd1);
   endtask

   initial begin
      logic [7:0] exp_bytes [4];
      logic       exp_order [10];
      word_t      saved_mem_rd;
      int         k;
      bit         drained;
      exp_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      exp_order = '{GNT_MEM, GNT_MEM, GNT_MEM, GNT_MEM, GNT_IF,
                    GNT_MEM, GNT_MEM, GNT_MEM, GNT_MEM, GNT_IF};

      rst = 1'b1;
      if_stage_request = 1'b0; if_stage_address = '0; if_stage_data_size = '0;
      mem_stage_request = 1'b0; mem_stage_rw = 1'b0; mem_stage_address = '0;
      mem_stage_data_size = '0; mem_stage_write_data = '0;
      bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_read_data = '0;
      repeat (3) step();

      // IF read alone, then a back-to-back IF read at the next address.
      if_stage_address = 32'h100; if_stage_data_size = SIZE_WORD;
      force_rw = 0; force_vw = 0; use_fixed_rd = 1'b1; fixed_rd = 32'hDEADBEEF;
      if_left = 2; rst_cmd = 1'b0;
      clear_logs();
      run_until("if pair", 2, 2, 40);
      if (gnt_log.size() >= 2 && done_log.size() >= 2 && rise_log.size() >= 2) begin
         check("if first grant", 32'(gnt_log[0]), 32'(GNT_IF));
         check("if latency", 32'(done_log[0] - gcyc_log[0]), 32'd3);
         check("if first address", addr_log[0], 32'h100);
         check("idle gap", 32'(rise_log[1] - done_log[0]), 32'd2);
         check("if second address", addr_log[1], 32'h104);
      end
      for (int i = 0; i < 4; i++) check("if read byte", 32'(if_stage_read_data[i]), 32'(exp_bytes[i]));

      // Random traffic with stalls, junk rvalid and fields changing after grant.
      use_fixed_rd = 1'b0; force_rw = -1; force_vw = -1;
      scramble = 1'b1; junk = 1'b1; auto_req = 1'b1;
      repeat (1500) step();
      auto_req = 1'b0;
      k = 0; drained = 1'b0;
      while (!drained && k < 400) begin
         step(); k++;
         drained = if_left == 0 && mem_left == 0 && !act;
      end
      check("random drain", 32'(drained), 32'd1);

      // MEM byte write with two ready stalls and three rvalid stalls.
      scramble = 1'b0; junk = 1'b0;
      mem_stage_rw = 1'b1; mem_stage_address = 32'h2004; mem_stage_data_size = SIZE_BYTE;
      mem_stage_write_data = '0; mem_stage_write_data[0] = 8'h5A;
      force_rw = 2; force_vw = 3; saved_mem_rd = exp_mem_rd;
      mem_left = 1;
      clear_logs();
      run_until("mem write", 1, 1, 40);
      if (done_log.size() >= 1 && addr_log.size() >= 1) begin
         check("mem write latency", 32'(done_log[0] - gcyc_log[0]), 32'd8);
         check("mem write address", addr_log[0], 32'h2004);
      end
      check("mem read data kept", mem_stage_read_data, saved_mem_rd);

      // Both requesting from reset release: streak limit lets IF through every fifth grant.
      rst_cmd = 1'b1; step(); step();
      if_left = 50; mem_left = 50; scramble = 1'b1; junk = 1'b1; force_rw = -1; force_vw = -1;
      clear_logs(); rst_cmd = 1'b0;
      run_until("streak", 0, 10, 400);
      if (gnt_log.size() >= 10)
         for (int i = 0; i < 10; i++) check("grant order", 32'(gnt_log[i]), 32'(exp_order[i]));

      // Reset during RESP with a stale rvalid after it; the retry must complete.
      rst_cmd = 1'b1; if_left = 0; mem_left = 0; step(); step();
      scramble = 1'b0; junk = 1'b0;
      mem_stage_rw = 1'b0; mem_stage_address = 32'h3000; mem_stage_data_size = SIZE_WORD;
      force_rw = 0; force_vw = 2; use_fixed_rd = 1'b1; fixed_rd = 32'hCAFEF00D;
      mem_left = 1; rst_in_resp = 1'b1; rst_cmd = 1'b0;
      clear_logs();
      run_until("reset in resp", 1, 2, 60);
      check("reset in resp grants", 32'(gnt_log.size()), 32'd2);
      check("reset in resp dones", 32'(done_log.size()), 32'd1);
      check("retry read data", mem_stage_read_data, 32'hCAFEF00D);

      // Random tail including occasional resets.
      use_fixed_rd = 1'b0; force_rw = -1; force_vw = -1;
      scramble = 1'b1; junk = 1'b1; auto_req = 1'b1; rand_rst = 1'b1;
      repeat (1500) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
